// File: rtl/video_frame_sched.sv
// video_frame_sched: frame-level sequencer for the binarize/erode/dilate video
// pipeline. A host command asks for N frames in a chosen mode. The block arms,
// waits for a clean frame start, and enables the processing stages for exactly
// N whole frames. It checks each frame's geometry, then keeps the stages enabled
// for a fixed drain period to flush pipeline latency, and finally pulses done.
//
// Optional build macro: VIDEO_FRAME_SCHED_TIMEOUT_EN
//   When defined, a watchdog ends a run when no video_vs edge arrives within
//   TIMEOUT_CYCLES clocks in ARM or RUN. The run then goes straight to DONE
//   with the timeout flag set. When undefined, no watchdog is built and
//   timeout is tied low.
module video_frame_sched #(
    parameter int IMG_WIDTH      = 1280,
    parameter int IMG_HEIGHT     = 720,
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       video_clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic [7:0] cfg_frames,
    input  logic [1:0] cfg_mode,
    input  logic       abort,
    input  logic       video_vs,
    input  logic       video_de,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       timeout,
    output logic       geom_err,
    output logic       stage_en,
    output logic [1:0] mode_out,
    output logic [7:0] frame_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [11:0] IMG_W_C      = 12'(IMG_WIDTH);
    localparam logic [11:0] IMG_H_C      = 12'(IMG_HEIGHT);
    localparam logic [7:0]  DRAIN_LOAD_C = 8'(DRAIN_CYCLES - 1);

    // Saturating increment for the 12-bit geometry counters.
    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        if (v == 12'hFFF) begin
            return v;
        end else begin
            return v + 12'd1;
        end
    endfunction

    logic [2:0]  state_q, state_d;
    logic [7:0]  frames_q, frames_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [7:0]  drain_cnt_q, drain_cnt_d;
    logic        aborted_q, aborted_d;
    logic        geom_err_q, geom_err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        stage_en_q, stage_en_d;
    logic        vs_d_q, de_d_q;

    logic        vs_rise_s, vs_fall_s, de_fall_s;
    logic        accept_s;
    logic        pix_bad_s, line_bad_s;
    logic [11:0] line_after_s;
    logic [7:0]  frame_inc_s;
    logic        to_fire_s;

    assign vs_rise_s = video_vs & ~vs_d_q;
    assign vs_fall_s = ~video_vs & vs_d_q;
    assign de_fall_s = ~video_de & de_d_q;

    assign accept_s = (state_q == S_IDLE) && cfg_start && (cfg_frames != 8'd0);

    // A line closing and a frame closing in the same cycle are both honoured:
    // the frame check sees the line count including the line that just ended.
    assign pix_bad_s    = de_fall_s && (pix_cnt_q != IMG_W_C);
    assign line_after_s = de_fall_s ? sat_inc12(line_cnt_q) : line_cnt_q;
    assign line_bad_s   = vs_fall_s && (line_after_s != IMG_H_C);
    assign frame_inc_s  = frame_cnt_q + 8'd1;

`ifdef VIDEO_FRAME_SCHED_TIMEOUT_EN
    localparam logic [23:0] TO_LAST_C = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    // A vs edge in the expiry cycle proves the video is alive, so it wins.
    assign to_fire_s = ((state_q == S_ARM) || (state_q == S_RUN)) &&
                       (to_cnt_q == TO_LAST_C) && !vs_rise_s && !vs_fall_s;

    // Watchdog counter and sticky timeout flag, next-state.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if ((state_d != state_q) || vs_rise_s || vs_fall_s) begin
            to_cnt_d = 24'd0;
        end else if ((state_q == S_ARM) || (state_q == S_RUN)) begin
            to_cnt_d = to_cnt_q + 24'd1;
        end else begin
            to_cnt_d = 24'd0;
        end
        if (accept_s) begin
            timeout_d = 1'b0;
        end else if (to_fire_s && !abort) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= 24'd0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_s;

    assign to_fire_s        = 1'b0;
    assign timeout          = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

    // Sequencer next-state: command acceptance, frame/geometry accounting, drain.
    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        drain_cnt_d = drain_cnt_q;
        aborted_d   = aborted_q;
        geom_err_d  = geom_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    frames_d    = cfg_frames;
                    mode_d      = cfg_mode;
                    aborted_d   = 1'b0;
                    geom_err_d  = 1'b0;
                    frame_cnt_d = 8'd0;
                    state_d     = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                // Only a fresh rising edge starts a run, never the middle of a frame.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (vs_rise_s) begin
                    pix_cnt_d  = 12'd0;
                    line_cnt_d = 12'd0;
                    state_d    = S_RUN;
                end else if (to_fire_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_RUN: begin
                if (de_fall_s) begin
                    pix_cnt_d = 12'd0;
                end else if (video_de) begin
                    pix_cnt_d = sat_inc12(pix_cnt_q);
                end else begin
                    pix_cnt_d = pix_cnt_q;
                end
                if (vs_fall_s) begin
                    frame_cnt_d = frame_inc_s;
                    line_cnt_d  = 12'd0;
                end else begin
                    line_cnt_d = line_after_s;
                end
                if (pix_bad_s || line_bad_s) begin
                    geom_err_d = 1'b1;
                end else begin
                    geom_err_d = geom_err_q;
                end
                // A frame ending in the abort cycle is counted above before leaving.
                if (abort) begin
                    aborted_d   = 1'b1;
                    drain_cnt_d = DRAIN_LOAD_C;
                    state_d     = S_DRAIN;
                end else if (vs_fall_s && (frame_inc_s == frames_q)) begin
                    drain_cnt_d = DRAIN_LOAD_C;
                    state_d     = S_DRAIN;
                end else if (to_fire_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 8'd1;
                    state_d     = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output strobes follow the state being entered so they register cleanly.
    always_comb begin
        busy_d     = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
        stage_en_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    // Sequencer state, counters, edge-detect history and registered outputs.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            frames_q    <= 8'd0;
            mode_q      <= 2'd0;
            frame_cnt_q <= 8'd0;
            pix_cnt_q   <= 12'd0;
            line_cnt_q  <= 12'd0;
            drain_cnt_q <= 8'd0;
            aborted_q   <= 1'b0;
            geom_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_en_q  <= 1'b0;
            vs_d_q      <= 1'b0;
            de_d_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frames_q    <= frames_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            aborted_q   <= aborted_d;
            geom_err_q  <= geom_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_en_q  <= stage_en_d;
            vs_d_q      <= video_vs;
            de_d_q      <= video_de;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign geom_err  = geom_err_q;
    assign stage_en  = stage_en_q;
    assign mode_out  = mode_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_frame_sched.sv
// Directed testbench for video_frame_sched with a small 16x8 frame geometry
// and a 4-cycle drain.
module tb_video_frame_sched;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int D  = 4;
    localparam int TO = 100;

    logic       video_clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic [7:0] cfg_frames;
    logic [1:0] cfg_mode;
    logic       abort;
    logic       video_vs;
    logic       video_de;
    logic       busy, done, aborted, timeout, geom_err, stage_en;
    logic [1:0] mode_out;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int en_seen = 0;
    int snap_done;
    int snap_en;

    always #5 video_clk = ~video_clk;

    video_frame_sched #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(TO)
    ) dut (
        .video_clk(video_clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_frames(cfg_frames), .cfg_mode(cfg_mode), .abort(abort),
        .video_vs(video_vs), .video_de(video_de), .busy(busy), .done(done),
        .aborted(aborted), .timeout(timeout), .geom_err(geom_err),
        .stage_en(stage_en), .mode_out(mode_out), .frame_cnt(frame_cnt)
    );

    // Cycle counters for done pulses and stage_en-high cycles.
    always @(posedge video_clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
        if (stage_en === 1'b1) en_seen <= en_seen + 1;
    end

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] n, input logic [1:0] m);
        cfg_start  = 1'b1;
        cfg_frames = n;
        cfg_mode   = m;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic send_line(input int npix);
        video_de = 1'b1;
        repeat (npix) tick();
        video_de = 1'b0;
        tick();
    endtask

    task automatic frame_body(input int nlines);
        video_vs = 1'b1;
        tick();
        tick();
        for (int i = 0; i < nlines; i++) send_line(W);
        video_vs = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string tag, input int max, input int exp_n);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, n, exp_n);
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_frames = 8'd0; cfg_mode = 2'd0;
        abort = 1'b0; video_vs = 1'b0; video_de = 1'b0;
        tick(); tick();
        check("reset_outs", {busy, done, aborted, timeout, geom_err, stage_en, mode_out, frame_cnt}, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

`ifdef VIDEO_FRAME_SCHED_TIMEOUT_EN
        // Watchdog: armed with video_vs held low.
        snap_en = en_seen;
        start(8'd1, 2'd0);
        wait_done("to", 200, TO);
        check("to_flag", timeout, 1);
        check("to_en", en_seen - snap_en, 0);
        tick();
        check("to_busy", busy, 0);
`endif

        // Nominal: two frames in mode 2, then an extra frame after completion.
        start(8'd2, 2'd2);
        check("nom_busy", busy, 1);
        check("nom_en0", stage_en, 0);
        check("nom_mode", mode_out, 2);
        tick(); tick();
        video_vs = 1'b1;
        tick();
        check("nom_en_rise", stage_en, 1);
        tick();
        for (int i = 0; i < H; i++) send_line(W);
        video_vs = 1'b0;
        tick();
        check("nom_fc1", frame_cnt, 1);
        repeat (3) tick();
        check("nom_gap_en", stage_en, 1);
        frame_body(H);
        check("nom_fc2", frame_cnt, 2);
        check("nom_drain_en", stage_en, 1);
        repeat (3) tick();
        check("nom_done_early", done, 0);
        check("nom_drain_en_end", stage_en, 1);
        tick();
        check("nom_done", done, 1);
        check("nom_en_off", stage_en, 0);
        check("nom_busy_off", busy, 0);
        check("nom_geom", geom_err, 0);
        tick();
        check("nom_done_once", done, 0);
        tick(); tick();
        frame_body(H);
        check("nom_fc_hold", frame_cnt, 2);
        check("nom_mode_hold", mode_out, 2);

        // Mid-frame arm: the in-progress frame must not be counted.
        video_vs = 1'b1;
        tick(); tick();
        start(8'd1, 2'd1);
        check("mid_busy", busy, 1);
        send_line(W);
        send_line(W);
        video_vs = 1'b0;
        tick();
        check("mid_en_partial", stage_en, 0);
        check("mid_fc_partial", frame_cnt, 0);
        tick(); tick();
        video_vs = 1'b1;
        tick();
        check("mid_en_rise", stage_en, 1);
        tick();
        for (int i = 0; i < H; i++) send_line(W);
        video_vs = 1'b0;
        tick();
        check("mid_fc", frame_cnt, 1);
        wait_done("mid", 10, D);
        check("mid_geom", geom_err, 0);
        tick(); tick();

        // Geometry A: one short line.
        start(8'd1, 2'd3);
        tick();
        video_vs = 1'b1;
        tick(); tick();
        send_line(W);
        check("geomA_pre", geom_err, 0);
        send_line(W - 1);
        check("geomA_line", geom_err, 1);
        for (int i = 0; i < H - 2; i++) send_line(W);
        video_vs = 1'b0;
        tick();
        check("geomA_fc", frame_cnt, 1);
        wait_done("geomA", 10, D);
        check("geomA_sticky", geom_err, 1);
        tick(); tick();

        // Geometry B: one frame short by a line.
        start(8'd1, 2'd3);
        check("geomB_clear", geom_err, 0);
        tick();
        video_vs = 1'b1;
        tick(); tick();
        for (int i = 0; i < H - 1; i++) send_line(W);
        check("geomB_pre", geom_err, 0);
        video_vs = 1'b0;
        tick();
        check("geomB_frame", geom_err, 1);
        wait_done("geomB", 10, D);
        tick(); tick();

        // Abort in RUN during frame 1 of 3, held through the drain.
        start(8'd3, 2'd1);
        tick();
        video_vs = 1'b1;
        tick(); tick();
        send_line(W);
        send_line(W);
        abort = 1'b1;
        tick();
        check("abr_flag", aborted, 1);
        check("abr_fc", frame_cnt, 0);
        check("abr_en", stage_en, 1);
        repeat (3) tick();
        check("abr_en_last", stage_en, 1);
        check("abr_done_early", done, 0);
        tick();
        check("abr_done", done, 1);
        check("abr_en_off", stage_en, 0);
        abort = 1'b0;
        video_vs = 1'b0;
        tick(); tick();
        check("abr_sticky", aborted, 1);

        // cfg_frames == 0 is ignored and leaves flags alone.
        start(8'd0, 2'd3);
        check("zero_busy", busy, 0);
        check("zero_abr_keep", aborted, 1);
        check("zero_mode_keep", mode_out, 1);
        tick(); tick();
        check("zero_busy2", busy, 0);

        // Abort in ARM: back to idle, no done, aborted stays clear.
        start(8'd1, 2'd2);
        check("arm_busy", busy, 1);
        check("arm_abr_clear", aborted, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("arm_abort_busy", busy, 0);
        snap_done = done_seen;
        snap_en = en_seen;
        frame_body(H);
        repeat (6) tick();
        check("arm_no_done", done_seen - snap_done, 0);
        check("arm_no_en", en_seen - snap_en, 0);
        check("arm_abr", aborted, 0);

        // Second cfg_start during RUN is ignored.
        start(8'd1, 2'd0);
        tick();
        video_vs = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) send_line(W);
        start(8'd3, 2'd3);
        for (int i = 0; i < 4; i++) send_line(W);
        video_vs = 1'b0;
        tick();
        check("restart_fc", frame_cnt, 1);
        check("restart_mode", mode_out, 0);
        wait_done("restart", 10, D);
        tick(); tick();

        // Reset asserted mid-RUN.
        start(8'd2, 2'd2);
        tick();
        video_vs = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) send_line(W);
        video_de = 1'b1;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_outs", {busy, done, aborted, timeout, geom_err, stage_en, mode_out, frame_cnt}, 0);
        tick();
        rst_n = 1'b1;
        video_de = 1'b0;
        snap_done = done_seen;
        tick();
        send_line(W);
        video_vs = 1'b0;
        tick();
        repeat (8) tick();
        check("rst_no_done", done_seen - snap_done, 0);
        check("rst_busy", busy, 0);
        check("rst_fc", frame_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/video_frame_sched.md
Name: video_frame_sched

Overview:
- Frame-level sequencer for the binarize/erode/dilate video pipeline.
- Accepts a host command to process N frames in a selected mode, arms on a frame boundary, and enables the pipeline for exactly N whole frames.
- Checks per-frame geometry against IMG_WIDTH×IMG_HEIGHT, flushes pipeline latency, then reports completion.
- Sits between the control interface and the video source/processing stages, all on video_clk.

Parameters:
IMG_WIDTH, 1280, expected active pixels per line
IMG_HEIGHT, 720, expected active lines per frame
DRAIN_CYCLES, 16, clocks stage_en stays high after the last frame, to flush pipeline latency
TIMEOUT_CYCLES, 2000000, watchdog limit without a video_vs edge (optional feature only)

Ports:
video_clk  in  1  pixel clock; all logic is on its rising edge
rst_n  in  1  asynchronous, active-low reset
cfg_start  in  1  one-cycle command strobe
cfg_frames  in  8  number of frames to process; 0 is invalid
cfg_mode  in  2  0=bypass, 1=binarize, 2=erode, 3=dilate
abort  in  1  level; requests early stop
video_vs  in  1  high while a frame is active; rising edge = frame start, falling edge = frame end
video_de  in  1  active-pixel strobe
busy  out  1  high in ARM, RUN and DRAIN
done  out  1  one-cycle completion pulse
aborted  out  1  sticky; set when a run ends due to abort
timeout  out  1  sticky watchdog flag; tied 0 without the macro
geom_err  out  1  sticky geometry mismatch flag
stage_en  out  1  enable to the processing stages
mode_out  out  2  latched cfg_mode
frame_cnt  out  8  frames completed in the current run

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, vs_d=0, de_d=0.
- Edge detect: vs_d and de_d are registered copies of video_vs and video_de.
  - vs_rise = video_vs & ~vs_d; vs_fall = ~video_vs & vs_d; de_fall = ~video_de & de_d.
- State IDLE:
  - cfg_start with cfg_frames != 0: latch frames and mode; clear aborted, timeout, geom_err and frame_cnt; go to ARM.
  - cfg_start with cfg_frames == 0: ignored, no flag changes.
  - cfg_start in any other state: ignored.
- State ARM:
  - Waits for vs_rise. If video_vs is already high at arm time, waits for the next rising edge; no mid-frame start.
  - On vs_rise: go to RUN; clear the pixel and line counters. stage_en is registered and rises on the first cycle in RUN.
  - abort while in ARM: return to IDLE, no done pulse, aborted=0.
- State RUN:
  - pix_cnt (12-bit, saturating at 4095) increments on each cycle with video_de=1.
  - On de_fall: if pix_cnt != IMG_WIDTH, set geom_err. Then clear pix_cnt and increment line_cnt (12-bit, saturating).
  - On vs_fall: if line_cnt != IMG_HEIGHT, set geom_err. Increment frame_cnt and clear line_cnt.
    - If the new frame_cnt == frames: go to DRAIN.
    - Otherwise stay in RUN; stage_en stays high across the frame gap.
  - abort in RUN: set aborted, go to DRAIN. A vs_fall in the same cycle is still counted and checked first.
  - video_de outside RUN is ignored.
- State DRAIN:
  - 8-bit down-counter loaded with DRAIN_CYCLES-1; stage_en held high.
  - When the counter reaches 0: go to DONE, and stage_en drops on entry to DONE.
  - abort in DRAIN has no effect.
- State DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Flags persist until the next accepted cfg_start: aborted, geom_err, timeout, frame_cnt, mode_out.
- Reset asserted mid-run: immediate return to IDLE with every output 0; no done pulse afterwards.

Optional Feature:
- Macro: VIDEO_FRAME_SCHED_TIMEOUT_EN.
- Defined:
  - A 24-bit counter runs in ARM and RUN; it clears on any vs_rise or vs_fall and on state entry.
  - When it reaches TIMEOUT_CYCLES-1: set timeout, force stage_en=0, and go directly to DONE (skip DRAIN).
- Undefined: no counter is built; timeout is tied 0; ARM may wait indefinitely.

Test Plan:
- Setup for all cases: IMG_WIDTH=16, IMG_HEIGHT=8, DRAIN_CYCLES=4.
- Nominal run: cfg_frames=2, mode=2, three clean frames → stage_en rises 1 cycle after the first vs_rise; frame_cnt=2 at the second vs_fall; done pulses 5 cycles after that vs_fall; geom_err=0; mode_out=2.
- Mid-frame arm: cfg_start while video_vs=1 → stage_en stays 0 until the next vs_rise; exactly 1 frame counted for cfg_frames=1.
- Geometry error: one line carries 15 de pixels, and separately a frame carries 7 lines → geom_err=1 after the respective de_fall/vs_fall; the run still completes with done=1.
- Abort: abort in RUN during frame 1 of 3 → aborted=1, frame_cnt=0, stage_en high 4 more cycles, then done; abort in ARM → busy=0 next cycle, no done.
- Boundary commands: cfg_frames=0 → ignored, busy stays 0; a second cfg_start during RUN → ignored, latched frames unchanged; rst_n low mid-RUN → all outputs 0 at once.
- Timeout (macro defined, TIMEOUT_CYCLES=100): arm with video_vs held 0 → timeout=1 and done after 100 cycles; stage_en never rises.
